// File: rtl/cve2_multdiv_issue.sv
// Issue side of the RV32M multiply/divide interface: latches one M-instruction, drives the
// multdiv unit, owns its intermediate registers and buffers the result toward writeback.
// Optional: define CVE2_MULDIV_DIVZERO_SHORTCUT_EN to answer divide-by-zero without issuing.
module cve2_multdiv_issue #(
  parameter int unsigned IMD_W = 34,
  parameter int unsigned RD_W  = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_op_a_i,
  input  logic [31:0]           req_op_b_i,
  input  logic [RD_W-1:0]       req_rd_i,
  input  logic                  flush_i,

  output logic                  md_mult_en_o,
  output logic                  md_div_en_o,
  output logic                  md_mult_sel_o,
  output logic                  md_div_sel_o,
  output logic [1:0]            md_operator_o,
  output logic [1:0]            md_signed_mode_o,
  output logic [31:0]           md_op_a_o,
  output logic [31:0]           md_op_b_o,
  input  logic [2*IMD_W-1:0]    md_imd_val_d_i,
  input  logic [1:0]            md_imd_val_we_i,
  output logic [2*IMD_W-1:0]    md_imd_val_q_o,
  output logic                  md_ready_id_o,
  input  logic [31:0]           md_result_i,
  input  logic                  md_valid_i,

  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_result_o,
  output logic [RD_W-1:0]       rsp_rd_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       op_a_q, op_b_q, result_q;
  logic [2:0]        funct3_q;
  logic [RD_W-1:0]   rd_q;
  logic              drop_q;
  logic [IMD_W-1:0]  imd0_q, imd1_q;
  logic              accept;
  logic              div_zero;

  assign accept = (state_q == IDLE) && req_valid_i;

`ifdef CVE2_MULDIV_DIVZERO_SHORTCUT_EN
  assign div_zero = req_funct3_i[2] && (req_op_b_i == 32'h0);
`else
  assign div_zero = 1'b0;
`endif

  // NOTE: sequential state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal written in an always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = div_zero ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (md_valid_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // A dropped result never handshakes; a flush here retires the visible response.
        if (drop_q || flush_i || rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o   = 1'b0;
    md_mult_en_o  = 1'b0;
    md_div_en_o   = 1'b0;
    md_mult_sel_o = 1'b0;
    md_div_sel_o  = 1'b0;
    md_ready_id_o = 1'b0;
    rsp_valid_o   = 1'b0;
    unique case (state_q)
      IDLE: req_ready_o = 1'b1;
      ISSUE: begin
        md_mult_sel_o = ~funct3_q[2];
        md_div_sel_o  = funct3_q[2];
        md_mult_en_o  = ~funct3_q[2];
        md_div_en_o   = funct3_q[2];
        md_ready_id_o = 1'b1;
      end
      RESP:    rsp_valid_o = ~drop_q;
      default: ;
    endcase
  end

  // Operator and signedness come from the latched funct3 so they stay stable while issued.
  always_comb begin
    md_operator_o    = 2'd0;
    md_signed_mode_o = 2'b00;
    unique case (funct3_q)
      3'b000: begin md_operator_o = 2'd0; md_signed_mode_o = 2'b00; end
      3'b001: begin md_operator_o = 2'd1; md_signed_mode_o = 2'b11; end
      3'b010: begin md_operator_o = 2'd1; md_signed_mode_o = 2'b01; end
      3'b011: begin md_operator_o = 2'd1; md_signed_mode_o = 2'b00; end
      3'b100: begin md_operator_o = 2'd2; md_signed_mode_o = 2'b11; end
      3'b101: begin md_operator_o = 2'd2; md_signed_mode_o = 2'b00; end
      3'b110: begin md_operator_o = 2'd3; md_signed_mode_o = 2'b11; end
      3'b111: begin md_operator_o = 2'd3; md_signed_mode_o = 2'b00; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_a_q   <= 32'h0;
      op_b_q   <= 32'h0;
      funct3_q <= 3'b000;
      rd_q     <= '0;
      drop_q   <= 1'b0;
      result_q <= 32'h0;
    end else begin
      if (accept) begin
        op_a_q   <= req_op_a_i;
        op_b_q   <= req_op_b_i;
        funct3_q <= req_funct3_i;
        rd_q     <= req_rd_i;
        drop_q   <= 1'b0;
        if (div_zero) begin
          // funct3[1] distinguishes REM/REMU (return dividend) from DIV/DIVU (all ones).
          result_q <= req_funct3_i[1] ? req_op_a_i : 32'hFFFF_FFFF;
        end
      end
      if (state_q == ISSUE) begin
        if (flush_i) begin
          drop_q <= 1'b1;
        end
        if (md_valid_i) begin
          result_q <= md_result_i;
        end
      end
    end
  end

  // NOTE: the intermediate registers are real flops owned by this block, so they take the
  // asynchronous reset like any other state even though the multdiv unit rewrites them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      imd0_q <= '0;
      imd1_q <= '0;
    end else begin
      if (md_imd_val_we_i[0]) begin
        imd0_q <= md_imd_val_d_i[2*IMD_W-1:IMD_W];
      end
      if (md_imd_val_we_i[1]) begin
        imd1_q <= md_imd_val_d_i[IMD_W-1:0];
      end
    end
  end

  assign md_imd_val_q_o = {imd0_q, imd1_q};
  assign md_op_a_o      = op_a_q;
  assign md_op_b_o      = op_b_q;
  assign rsp_result_o   = result_q;
  assign rsp_rd_o       = rd_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_cve2_multdiv_issue.sv
// Self-checking bench for cve2_multdiv_issue: the bench plays the multdiv unit and checks
// issue outputs, results and handshakes against an instruction-level reference model.
module tb_cve2_multdiv_issue;

  localparam int RD_W = 5;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [2:0]   req_funct3_i = 3'b000;
  logic [31:0]  req_op_a_i = 32'h0;
  logic [31:0]  req_op_b_i = 32'h0;
  logic [4:0]   req_rd_i = 5'd0;
  logic         flush_i = 1'b0;
  logic         md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
  logic [1:0]   md_operator_o, md_signed_mode_o;
  logic [31:0]  md_op_a_o, md_op_b_o;
  logic [67:0]  md_imd_val_d_i = '0;
  logic [1:0]   md_imd_val_we_i = 2'b00;
  logic [67:0]  md_imd_val_q_o;
  logic         md_ready_id_o;
  logic [31:0]  md_result_i = 32'h0;
  logic         md_valid_i = 1'b0;
  logic         rsp_valid_o;
  logic         rsp_ready_i = 1'b0;
  logic [31:0]  rsp_result_o;
  logic [4:0]   rsp_rd_o;
  logic         busy_o;

  cve2_multdiv_issue #(.IMD_W(34), .RD_W(RD_W)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_funct3_i     (req_funct3_i),
    .req_op_a_i       (req_op_a_i),
    .req_op_b_i       (req_op_b_i),
    .req_rd_i         (req_rd_i),
    .flush_i          (flush_i),
    .md_mult_en_o     (md_mult_en_o),
    .md_div_en_o      (md_div_en_o),
    .md_mult_sel_o    (md_mult_sel_o),
    .md_div_sel_o     (md_div_sel_o),
    .md_operator_o    (md_operator_o),
    .md_signed_mode_o (md_signed_mode_o),
    .md_op_a_o        (md_op_a_o),
    .md_op_b_o        (md_op_b_o),
    .md_imd_val_d_i   (md_imd_val_d_i),
    .md_imd_val_we_i  (md_imd_val_we_i),
    .md_imd_val_q_o   (md_imd_val_q_o),
    .md_ready_id_o    (md_ready_id_o),
    .md_result_i      (md_result_i),
    .md_valid_i       (md_valid_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_result_o     (rsp_result_o),
    .rsp_rd_o         (rsp_rd_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [1:0]  op;
    logic [1:0]  sm;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RV32M semantics per instruction, computed in 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f3)
      3'b000: begin p = sa * sb; return p[31:0];  end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'b101: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'b110: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic logic [3:0] spec_decode(input logic [2:0] f3);
    case (f3)
      3'b000: return 4'b00_00;
      3'b001: return 4'b01_11;
      3'b010: return 4'b01_01;
      3'b011: return 4'b01_00;
      3'b100: return 4'b10_11;
      3'b101: return 4'b10_00;
      3'b110: return 4'b11_11;
      default: return 4'b11_00;
    endcase
  endfunction

  // Stand-in for the multdiv unit: computes from what the DUT actually issued.
  function automatic logic [31:0] md_stub(input logic [1:0] op, input logic [1:0] sm,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea, eb, p;
    ea = sm[0] ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sm[1] ? {{32{b[31]}}, b} : {32'h0, b};
    if (op == 2'd0) begin p = ea * eb; return p[31:0]; end
    if (op == 2'd1) begin p = ea * eb; return p[63:32]; end
    if (b == 32'h0) return (op == 2'd2) ? 32'hFFFF_FFFF : a;
    p = (op == 2'd2) ? (ea / eb) : (ea % eb);
    return p[31:0];
  endfunction

  // flush_mode: 0 none, 1 flush in the first issue cycle, 2 flush instead of rsp_ready.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [1:0] e_op,
                       input logic [1:0] e_sm, input logic [31:0] e_res, input int lat,
                       input int rdy_wait, input int flush_mode);
    bit shortcut;
    bit dropped;
`ifdef CVE2_MULDIV_DIVZERO_SHORTCUT_EN
    shortcut = f3[2] && (b == 32'h0);
`else
    shortcut = 1'b0;
`endif
    dropped = (flush_mode == 1) && !shortcut;
    check({tag, " req_ready idle"}, req_ready_o, 1'b1);
    req_valid_i = 1'b1; req_funct3_i = f3; req_op_a_i = a; req_op_b_i = b; req_rd_i = rd;
    step();
    req_valid_i = 1'b0; req_op_a_i = $urandom; req_op_b_i = $urandom;
    req_funct3_i = 3'($urandom); req_rd_i = 5'($urandom);
    check({tag, " busy"}, busy_o, 1'b1);
    check({tag, " req_ready busy"}, req_ready_o, 1'b0);
    if (!shortcut) begin
      check({tag, " operator"}, md_operator_o, e_op);
      check({tag, " signed_mode"}, md_signed_mode_o, e_sm);
      check({tag, " op_a"}, md_op_a_o, a);
      check({tag, " op_b"}, md_op_b_o, b);
      check({tag, " mult_sel"}, md_mult_sel_o, !f3[2]);
      check({tag, " div_sel"}, md_div_sel_o, f3[2]);
      for (int i = 0; i < lat; i++) begin
        check({tag, " mult_en"}, md_mult_en_o, !f3[2]);
        check({tag, " div_en"}, md_div_en_o, f3[2]);
        check({tag, " ready_id"}, md_ready_id_o, 1'b1);
        check({tag, " rsp_valid issue"}, rsp_valid_o, 1'b0);
        flush_i = (flush_mode == 1) && (i == 0);
        if (i == lat - 1) begin
          md_valid_i  = 1'b1;
          md_result_i = md_stub(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
        end
        step();
        flush_i = 1'b0; md_valid_i = 1'b0; md_result_i = $urandom;
      end
    end
    check({tag, " enables off"}, {md_mult_en_o, md_div_en_o, md_ready_id_o}, 3'b000);
    if (dropped) begin
      check({tag, " dropped rsp_valid"}, rsp_valid_o, 1'b0);
      step();
      check({tag, " dropped rsp_valid after"}, rsp_valid_o, 1'b0);
      check({tag, " dropped back idle"}, {busy_o, req_ready_o}, 2'b01);
      return;
    end
    check({tag, " rsp_valid"}, rsp_valid_o, 1'b1);
    check({tag, " result"}, rsp_result_o, e_res);
    check({tag, " rd"}, rsp_rd_o, rd);
    for (int i = 0; i < rdy_wait; i++) begin
      step();
      check({tag, " hold valid"}, rsp_valid_o, 1'b1);
      check({tag, " hold result"}, rsp_result_o, e_res);
      check({tag, " hold rd"}, rsp_rd_o, rd);
      check({tag, " hold req_ready/en"}, {req_ready_o, md_mult_en_o, md_div_en_o}, 3'b000);
    end
    if (flush_mode == 2) flush_i = 1'b1;
    else rsp_ready_i = 1'b1;
    step();
    flush_i = 1'b0; rsp_ready_i = 1'b0;
    check({tag, " retired valid"}, rsp_valid_o, 1'b0);
    check({tag, " retired idle"}, {busy_o, req_ready_o}, 2'b01);
  endtask

  initial begin
    logic [33:0] m0, m1;
    logic [67:0] d;
    logic [3:0]  dec;
    logic [2:0]  f3;
    logic [31:0] a, b;

    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  2'd0, 2'b00, 32'hFFFF_FFEB};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd31, 2'd1, 2'b11, 32'h4000_0000};
    vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  2'd1, 2'b01, 32'hFFFF_FFFF};
    vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  2'd1, 2'b00, 32'hFFFF_FFFE};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  2'd2, 2'b11, 32'hFFFF_FFFD};
    vecs[5]  = '{3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  2'd2, 2'b00, 32'h7FFF_FFFC};
    vecs[6]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  2'd3, 2'b11, 32'hFFFF_FFFF};
    vecs[7]  = '{3'b111, 32'd17,        32'd5,         5'd7,  2'd3, 2'b00, 32'h0000_0002};
    vecs[8]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  2'd2, 2'b11, 32'h8000_0000};
    vecs[9]  = '{3'b101, 32'h1234_5678, 32'h0000_0000, 5'd9,  2'd2, 2'b00, 32'hFFFF_FFFF};
    vecs[10] = '{3'b110, 32'h1234_5678, 32'h0000_0000, 5'd10, 2'd3, 2'b11, 32'h1234_5678};

    // Reset values
    #1;
    check("reset req_ready", req_ready_o, 1'b1);
    check("reset rsp_valid/busy", {rsp_valid_o, busy_o}, 2'b00);
    check("reset md ctrl", {md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o,
                            md_ready_id_o, md_operator_o, md_signed_mode_o}, 9'h0);
    check("reset operands", {md_op_a_o, md_op_b_o}, 64'h0);
    check("reset imd", md_imd_val_q_o, 68'h0);
    check("reset result/rd", {rsp_result_o, rsp_rd_o}, 37'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
            vecs[i].op, vecs[i].sm, vecs[i].res, (i % 4) + 1, i % 2, 0);
    end

    // Writeback stalls for five cycles, then the next request is accepted straight away.
    do_op("stall", 3'b000, 32'd6, 32'd7, 5'd12, 2'd0, 2'b00, 32'd42, 2, 5, 0);
    do_op("after stall", 3'b111, 32'd17, 32'd5, 5'd13, 2'd3, 2'b00, 32'd2, 1, 0, 0);

    // Flush during a divide, in the response cycle, and while idle.
    do_op("flush issue", 3'b100, 32'd100, 32'd7, 5'd14, 2'd2, 2'b11, 32'd14, 3, 0, 1);
    do_op("flush resp", 3'b001, 32'h1, 32'h2, 5'd15, 2'd1, 2'b11, 32'h0, 1, 2, 2);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush idle ignored", {busy_o, req_ready_o}, 2'b01);
    do_op("after idle flush", 3'b000, 32'd9, 32'd9, 5'd16, 2'd0, 2'b00, 32'd81, 1, 0, 0);

    // Intermediate registers: each write-enable combination.
    m0 = '0; m1 = '0;
    for (int i = 0; i < 8; i++) begin
      d = {4'($urandom), $urandom, $urandom};
      md_imd_val_we_i = 2'(i);
      md_imd_val_d_i  = d;
      if (md_imd_val_we_i[0]) m0 = d[67:34];
      if (md_imd_val_we_i[1]) m1 = d[33:0];
      step();
      md_imd_val_we_i = 2'b00;
      md_imd_val_d_i  = {4'($urandom), $urandom, $urandom};
      check($sformatf("imd we=%0d", i % 4), md_imd_val_q_o, {m0, m1});
    end
    do_op("imd retained op", 3'b101, 32'd50, 32'd5, 5'd17, 2'd2, 2'b00, 32'd10, 2, 0, 0);
    check("imd retained", md_imd_val_q_o, {m0, m1});

    // Randomized instructions against the reference model.
    for (int n = 0; n < 30; n++) begin
      f3  = 3'($urandom);
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      dec = spec_decode(f3);
      do_op($sformatf("rand%0d", n), f3, a, b, 5'($urandom), dec[3:2], dec[1:0],
            ref_model(f3, a, b), $urandom_range(1, 4), $urandom_range(0, 3),
            ($urandom_range(0, 5) < 3) ? $urandom_range(0, 2) : 0);
    end

    // Reset in the middle of an issued multiply.
    if (m0 == 34'h0 && m1 == 34'h0) begin
      md_imd_val_we_i = 2'b11; md_imd_val_d_i = {34'h1, 34'h2};
      step();
      md_imd_val_we_i = 2'b00;
    end
    req_valid_i = 1'b1; req_funct3_i = 3'b000; req_op_a_i = 32'h55; req_op_b_i = 32'h3;
    req_rd_i = 5'd20;
    step();
    req_valid_i = 1'b0;
    check("midop mult_en", md_mult_en_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    check("midop reset busy/en", {busy_o, md_mult_en_o, md_div_en_o, md_ready_id_o}, 4'b0000);
    check("midop reset req_ready", req_ready_o, 1'b1);
    check("midop reset operands", {md_op_a_o, md_op_b_o, rsp_rd_o}, 69'h0);
    check("midop reset imd", md_imd_val_q_o, 68'h0);
    check("midop reset result", rsp_result_o, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    step();
    do_op("post reset", 3'b011, 32'h8000_0000, 32'h4, 5'd21, 2'd1, 2'b00, 32'h2, 2, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cve2_multdiv_issue.md
Name: cve2_multdiv_issue

Overview:
- Initiator side of the RV32M multiply/divide request interface.
- Accepts decoded M-extension instructions from the ID stage and drives the multdiv unit's enable, select, operator and operand inputs.
- Owns the two 34-bit intermediate-value registers that the multdiv unit writes back.
- Captures the result and presents it to writeback through a valid/ready buffer.

Parameters:
- IMD_W, 34, width of each intermediate-value register (fixed by the multdiv interface).
- RD_W, 5, destination register index width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  M-instruction request from ID
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_funct3_i  in  3  RV32M funct3
- req_op_a_i  in  32  rs1 value
- req_op_b_i  in  32  rs2 value
- req_rd_i  in  RD_W  destination register
- flush_i  in  1  discard the in-flight instruction's result
- md_mult_en_o  out  1  multiply enable to multdiv
- md_div_en_o  out  1  divide enable to multdiv
- md_mult_sel_o  out  1  multiply class selected
- md_div_sel_o  out  1  divide class selected
- md_operator_o  out  2  0=MUL, 1=MULH, 2=DIV, 3=REM
- md_signed_mode_o  out  2  bit0 = op_a signed, bit1 = op_b signed
- md_op_a_o  out  32  latched operand a
- md_op_b_o  out  32  latched operand b
- md_imd_val_d_i  in  68  intermediate write data
- md_imd_val_we_i  in  2  intermediate write enables
- md_imd_val_q_o  out  68  intermediate register contents
- md_ready_id_o  out  1  downstream ready toward multdiv
- md_result_i  in  32  multdiv result
- md_valid_i  in  1  multdiv result valid
- rsp_valid_o  out  1  result valid to writeback
- rsp_ready_i  in  1  writeback accepts result
- rsp_result_o  out  32  result
- rsp_rd_o  out  RD_W  destination register
- busy_o  out  1  block not idle

Behaviour:
- funct3 decode to (operator, signed_mode):
  - 000 → (0, 00)
  - 001 → (1, 11)
  - 010 → (1, 01)
  - 011 → (1, 00)
  - 100 → (2, 11)
  - 101 → (2, 00)
  - 110 → (3, 11)
  - 111 → (3, 00)
- Class selects: mult_sel = ~funct3[2]; div_sel = funct3[2].
- FSM IDLE → ISSUE → RESP → IDLE; state resets to IDLE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: latch op_a, op_b, funct3, rd; clear the drop flag; go to ISSUE.
- ISSUE:
  - md_mult_en_o = mult_sel; md_div_en_o = div_sel.
  - md_ready_id_o=1.
  - Operands, operator, signed_mode and sels are held stable from the latches.
  - On md_valid_i: capture md_result_i into rsp_result; deassert enables from the next cycle; go to RESP.
- RESP:
  - rsp_valid_o=1 unless the drop flag is set.
  - On rsp_ready_i, or immediately if dropped: go to IDLE.
  - Result and rd are held stable while rsp_valid_o=1 and rsp_ready_i=0.
- Enables, md_ready_id_o, req_ready_o and rsp_valid_o are 0 outside the states listed above.
- Latency: request accepted in cycle T; first enable in T+1; rsp_valid_o is asserted the cycle after md_valid_i is sampled. No back-to-back accept: the next request is accepted only in IDLE.
- Intermediate registers:
  - imd0 = bits 67:34, written from md_imd_val_d_i[67:34] when we[0].
  - imd1 = bits 33:0, written from md_imd_val_d_i[33:0] when we[1].
  - Both written in the same cycle if both enables are set.
  - Reset to 0; retain value otherwise; never cleared between instructions.
- Flush:
  - flush_i in ISSUE sets the drop flag; the operation runs to completion so the multdiv FSM returns to idle.
  - flush_i in RESP with rsp_valid_o=1 drops the response the same cycle (rsp_valid_o falls next cycle).
  - flush_i in IDLE is ignored.
- busy_o = (state != IDLE).
- Reset mid-operation: all state, latches, drop flag, result and imd registers return to 0 / IDLE. The multdiv unit is on the same reset.
- Reset values of outputs: all 0 except req_ready_o=1.

Optional Feature:
- Macro: CVE2_MULDIV_DIVZERO_SHORTCUT_EN.
- Defined: a divide-class request with op_b==0 skips ISSUE, with no md_div_en_o pulse.
  - Goes IDLE → RESP directly.
  - DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = op_a.
  - rsp_valid_o is asserted at T+1.
- Undefined: divide-by-zero is issued like any other division.

Test Plan:
- MUL 0x00000007 × 0xFFFFFFFD (funct3 000) → md_operator_o=0, signed_mode=00, rsp_result_o=0xFFFFFFEB, rd echoed.
- MULH 0x80000000 × 0x80000000 (funct3 001) → signed_mode=11, rsp_result_o=0x40000000.
- DIV 0xFFFFFFF9 / 0x00000002 (funct3 100) → rsp_result_o=0xFFFFFFFD; REMU 17/5 (funct3 111) → 0x00000002.
- rsp_ready_i held 0 for 5 cycles after rsp_valid_o → result and rd stable, req_ready_o=0, md enables 0; accept on cycle 6 → next request accepted the following cycle.
- flush_i pulsed in ISSUE during DIV → md_div_en_o held until md_valid_i, rsp_valid_o never asserts, block returns to IDLE.
- DIVU x/0 with macro defined → no md_div_en_o, rsp_result_o=0xFFFFFFFF at T+1. Without macro → issued, rsp_result_o=0xFFFFFFFF after md_valid_i.
